// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared constants for the SD-card SPI master.
// Contents: bus addresses, STATUS bit indices, FSM state type, divider helper.
package sd_spi_pkg;

    localparam logic [15:0] ADDR_DATA = 16'h0000;
    localparam logic [15:0] ADDR_CTRL = 16'h0001;

    localparam int ST_BUSY    = 0;
    localparam int ST_PRESENT = 1;
    localparam int ST_CS      = 2;
    localparam int ST_OVERRUN = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int calc_div(input int clk_freq, input int spi_freq);
        int d;
        d = clk_freq / (2 * spi_freq);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/sd_spi_master_clkdiv.sv
// sd_spi_clkdiv: emits a one-cycle tick every DIV enabled clk cycles.
// Ports: clk, rst (async active-low), en (counter held at 0 when low), tick.
module sd_spi_clkdiv #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = en && (cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else
            cnt <= (!en || tick) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/sd_spi_master.sv
// sd_spi_master: byte-wide SPI (mode 0) master for an SD card on a small register bus.
// Ports: clk, rst (async active-low); bus addr/mosi/miso/write; card sd_cs/sd_sck/
// sd_mosi/sd_miso/sd_det; debug (driven only when SD_SPI_DEBUG_EN is defined, else 0).
module sd_spi_master
    import sd_spi_pkg::*;
#(
    parameter int CLK_FREQ = 200_000_000,
    parameter int SPI_FREQ = 400_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  mosi,
    output logic [7:0]  miso,
    input  logic        write,
    output logic        sd_cs,
    output logic        sd_sck,
    output logic        sd_mosi,
    input  logic        sd_miso,
    input  logic        sd_det,
    output logic [7:0]  debug
);

    localparam int DIV = calc_div(CLK_FREQ, SPI_FREQ);

    state_t      state, state_n;
    logic        write_q, busy, tick, overrun;
    logic        data_wr, ctrl_wr;
    logic [1:0]  det_sync, miso_sync;
    logic [3:0]  bit_cnt;
    logic [7:0]  tx_sh, rx_sh, rx_byte, status;

    sd_spi_clkdiv #(.DIV(DIV)) u_clkdiv (
        .clk  (clk),
        .rst  (rst),
        .en   (state == SHIFT),
        .tick (tick)
    );

    // A write acts only on its first cycle.
    assign data_wr = write && !write_q && (addr == ADDR_DATA);
    assign ctrl_wr = write && !write_q && (addr == ADDR_CTRL);
    assign busy    = (state != IDLE);
    assign sd_mosi = (state == SHIFT) ? tx_sh[7] : 1'b1;

    always_comb begin
        status               = 8'h00;
        status[ST_BUSY]      = busy;
        status[ST_PRESENT]   = !det_sync[1];
        status[ST_CS]        = sd_cs;
        status[ST_OVERRUN]   = overrun;
        miso = (addr == ADDR_DATA) ? rx_byte : (addr == ADDR_CTRL) ? status : 8'h00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = data_wr ? SHIFT : IDLE;
            SHIFT:   state_n = (tick && bit_cnt == 4'd15) ? DONE : SHIFT;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // bit_cnt counts sck half-periods; even ticks rise (sample), odd ticks fall (shift).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_q   <= 1'b0;
            det_sync  <= 2'b11;
            miso_sync <= 2'b11;
            sd_cs     <= 1'b1;
            sd_sck    <= 1'b0;
            overrun   <= 1'b0;
            bit_cnt   <= 4'd0;
            tx_sh     <= 8'hFF;
            rx_sh     <= 8'hFF;
            rx_byte   <= 8'hFF;
        end else begin
            write_q   <= write;
            det_sync  <= {det_sync[0], sd_det};
            miso_sync <= {miso_sync[0], sd_miso};
            if (ctrl_wr) begin
                sd_cs <= mosi[0];
                if (mosi[7])
                    overrun <= 1'b0;
            end
            if (data_wr && busy)
                overrun <= 1'b1;
            if (state == IDLE) begin
                bit_cnt <= 4'd0;
                sd_sck  <= 1'b0;
                if (data_wr)
                    tx_sh <= mosi;
            end else if (state == SHIFT && tick) begin
                bit_cnt <= bit_cnt + 4'd1;
                sd_sck  <= !sd_sck;
                if (sd_sck)
                    tx_sh <= {tx_sh[6:0], 1'b1};
                else
                    rx_sh <= {rx_sh[6:0], miso_sync[1]};
            end
            if (state == DONE)
                rx_byte <= rx_sh;
        end
    end

`ifdef SD_SPI_DEBUG_EN
    assign debug = {2'(state), bit_cnt, sd_sck, busy};
`else
    assign debug = 8'h00;
`endif

endmodule

// File: tb/tb_sd_spi_master.sv
// tb_sd_spi_master: randomized self-checking bench for sd_spi_master against a
// transaction-level model (expected bytes, bit order, pulse count, transfer length).
module tb_sd_spi_master;

    localparam int CLK_FREQ = 8;
    localparam int SPI_FREQ = 1;
    localparam int DIV_EXP  = (CLK_FREQ / (2 * SPI_FREQ) < 1) ? 1 : CLK_FREQ / (2 * SPI_FREQ);
    localparam logic [15:0] A_DATA = 16'h0000;
    localparam logic [15:0] A_CTRL = 16'h0001;

    logic        clk = 1'b0;
    logic        rst, write, sd_det;
    logic [15:0] addr;
    logic [7:0]  mosi, miso, debug;
    logic        sd_cs, sd_sck, sd_mosi, sd_miso;

    bit          loop;
    logic [7:0]  pat, sent;
    int          fidx, pulses;
    int          n_cmp = 0, n_err = 0;
    bit          cs_exp = 1'b1, ov_exp = 1'b0, pres_exp = 1'b0;

    sd_spi_master #(.CLK_FREQ(CLK_FREQ), .SPI_FREQ(SPI_FREQ)) dut (
        .clk(clk), .rst(rst), .addr(addr), .mosi(mosi), .miso(miso), .write(write),
        .sd_cs(sd_cs), .sd_sck(sd_sck), .sd_mosi(sd_mosi), .sd_miso(sd_miso),
        .sd_det(sd_det), .debug(debug)
    );

    always #5 clk = ~clk;

    // Card side: either loops MOSI back or presents pattern bit fidx (MSB first).
    assign sd_miso = loop ? sd_mosi : ((fidx > 7) ? 1'b1 : pat[7 - fidx]);

    always @(posedge sd_sck) begin
        pulses = pulses + 1;
        sent   = {sent[6:0], sd_mosi};
    end

    always @(negedge sd_sck) fidx = fidx + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] stat_exp(input bit bz);
        return {4'b0, ov_exp, cs_exp, pres_exp, bz};
    endfunction

    task automatic model_wr(input logic [15:0] a, input logic [7:0] d, input bit bz);
        if (a == A_CTRL) begin
            cs_exp = d[0];
            if (d[7]) ov_exp = 1'b0;
        end else if (a == A_DATA && bz) begin
            ov_exp = 1'b1;
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk) addr = a; mosi = d; write = 1'b1;
        @(negedge clk) write = 1'b0;
        model_wr(a, d, 1'b0);
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk) addr = a;
        #1 d = miso;
    endtask

    task automatic xfer(input logic [7:0] b, input bit lp, input logic [7:0] p,
                        input bit inj, input logic [15:0] ia, input logic [7:0] id);
        int n;
        logic [7:0] d;
        loop = lp; pat = p; fidx = 0; pulses = 0; sent = 8'h00;
        @(negedge clk) addr = A_DATA; mosi = b; write = 1'b1;
        @(negedge clk) write = 1'b0; addr = A_CTRL;
        for (n = 0; n < 200; n++) begin
            #1;
            if (addr == A_CTRL && !miso[0]) break;
            if (inj && n == 12) begin
                chk("cs_during_busy", sd_cs, cs_exp);
                chk("status_during_busy", miso, stat_exp(1'b1));
            end
            @(negedge clk);
            if (inj && n == 9) begin
                addr = ia; mosi = id; write = 1'b1;
                model_wr(ia, id, 1'b1);
            end else if (inj && n == 10) begin
                addr = A_CTRL; write = 1'b0;
            end
        end
        chk("busy_cycles", n, 16 * DIV_EXP + 1);
        chk("sck_pulses", pulses, 8);
        chk("mosi_bits", sent, b);
        chk("mosi_idle", sd_mosi, 1'b1);
        chk("sck_idle", sd_sck, 1'b0);
        bus_rd(A_DATA, d);
        chk("data_read", d, lp ? b : p);
        bus_rd(A_CTRL, d);
        chk("status_after", d, stat_exp(1'b0));
        chk("cs_pin", sd_cs, cs_exp);
    endtask

    initial begin
        logic [7:0] d;
        int k;
        rst = 1'b0; write = 1'b0; addr = A_DATA; mosi = 8'h00; sd_det = 1'b1;
        loop = 1'b1; pat = 8'hFF; fidx = 0; pulses = 0; sent = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_cs", sd_cs, 1'b1);
        chk("rst_sck", sd_sck, 1'b0);
        chk("rst_mosi", sd_mosi, 1'b1);
        #1 chk("rst_data", miso, 8'hFF);
        addr = A_CTRL;
        #1 chk("rst_status", miso, stat_exp(1'b0));
`ifndef SD_SPI_DEBUG_EN
        chk("debug_off", debug, 8'h00);
`endif
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);

        // Card insertion: present must appear within 3 cycles.
        @(negedge clk) sd_det = 1'b0; addr = A_CTRL;
        for (k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 if (miso[1]) break;
        end
        chk("present_rise", miso[1], 1'b1);
        pres_exp = 1'b1;
        bus_rd(16'h0002, d);
        chk("unmapped_read", d, 8'h00);
        bus_wr(16'h0002, 8'h81);
        bus_rd(A_CTRL, d);
        chk("unmapped_write_ignored", d, stat_exp(1'b0));

        bus_wr(A_CTRL, 8'h00);
        chk("cs_low", sd_cs, 1'b0);
        bus_rd(A_CTRL, d);
        chk("status_cs_low", d, stat_exp(1'b0));

        xfer(8'hA5, 1'b1, 8'h00, 1'b0, A_DATA, 8'h00);
        xfer(8'hFF, 1'b0, 8'h00, 1'b0, A_DATA, 8'h00);

        xfer(8'($urandom), 1'b1, 8'h00, 1'b1, A_DATA, 8'h3C);
        chk("overrun_set", ov_exp, 1'b1);
        bus_wr(A_CTRL, 8'h80);
        bus_rd(A_CTRL, d);
        chk("overrun_clear", d, stat_exp(1'b0));

        xfer(8'($urandom), 1'b0, 8'($urandom), 1'b1, A_CTRL, 8'h01);
        xfer(8'($urandom), 1'b0, 8'($urandom), 1'b1, A_CTRL, 8'h00);

        for (int i = 0; i < 6; i++) begin
            int sel;
            sel = $urandom_range(0, 2);
            xfer(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), sel != 0,
                 (sel == 1) ? A_DATA : A_CTRL, 8'($urandom));
            if (ov_exp) bus_wr(A_CTRL, {1'b1, 6'b0, cs_exp});
        end

        // Reset asserted mid-transfer aborts without touching rx_byte.
        loop = 1'b0; pat = 8'h12; fidx = 0;
        @(negedge clk) addr = A_DATA; mosi = 8'h5A; write = 1'b1;
        @(negedge clk) write = 1'b0;
        repeat (29) @(negedge clk);
        addr = A_CTRL; rst = 1'b0;
        #1;
        chk("abort_sck", sd_sck, 1'b0);
        chk("abort_cs", sd_cs, 1'b1);
        chk("abort_busy", miso[0], 1'b0);
        chk("abort_mosi", sd_mosi, 1'b1);
        cs_exp = 1'b1; ov_exp = 1'b0;
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        bus_rd(A_DATA, d);
        chk("abort_data", d, 8'hFF);
        bus_rd(A_CTRL, d);
        chk("abort_status", d, stat_exp(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
